mux_n_seq: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer. It generalises the combinational 4:1 single-bit mux with three additions: registered output, an enable, and an auto-scan mode that steps through the channels on its own. It is used wherever a datapath needs to time-share one output among several sources, for example display or ADC-style channel scanning. The output carries channel-index and valid tags.

---
 rtl/mux_pkg.sv | 19 +
 rtl/scan_ctr.sv | 62 ++++++
 rtl/mux_n_seq.sv | 114 +++++++++++
 tb/tb_mux_n_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-channel multiplexer.
// Provides the mode encodings and a helper that extracts one channel from a flattened input bus.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Upper bounds for chan_slice: N*W must not exceed MAX_BUS_W and W must not exceed MAX_CH_W
  localparam int unsigned MAX_BUS_W = 4096;
  localparam int unsigned MAX_CH_W  = 256;

  // Returns channel k of a flattened bus of w-bit channels, zero-extended to MAX_CH_W bits
  function automatic logic [MAX_CH_W-1:0] chan_slice(input logic [MAX_BUS_W-1:0] bus,
                                                     input int unsigned         k,
                                                     input int unsigned         w);
    return MAX_CH_W'(bus >> (k * w));
  endfunction

endpackage

// File: rtl/scan_ctr.sv
// Scan pointer and dwell counter for the auto-scan mode.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   en   - advance enable; p and d are frozen while low
//   clr  - restart from channel 0, dwell 0 (scan entry or direct mode)
//   adv  - high in scan mode; low forces p and d to 0 on the next enabled edge
//   p    - current scan pointer
//   d    - current dwell count
module scan_ctr #(
  parameter  int unsigned N     = 4,
  parameter  int unsigned DWELL = 1,
  localparam int unsigned SW    = $clog2(N),
  localparam int unsigned DW    = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          adv,
  output logic [SW-1:0] p,
  output logic [DW-1:0] d
);

  logic [SW-1:0] r_p;
  logic [DW-1:0] r_d;
  logic [SW-1:0] w_p_base;
  logic [DW-1:0] w_d_base;
  logic [SW-1:0] w_p_nxt;
  logic [DW-1:0] w_d_nxt;

  // Step from the (possibly cleared) current position; direct mode parks at zero
  always_comb begin
    w_p_base = clr ? '0 : r_p;
    w_d_base = clr ? '0 : r_d;
    w_p_nxt  = '0;
    w_d_nxt  = '0;
    if (adv) begin
      if (w_d_base == DW'(DWELL - 1)) begin
        w_d_nxt = '0;
        w_p_nxt = (w_p_base == SW'(N - 1)) ? '0 : w_p_base + SW'(1);
      end else begin
        w_p_nxt = w_p_base;
        w_d_nxt = w_d_base + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
      r_d <= '0;
    end else if (en) begin
      r_p <= w_p_nxt;
      r_d <= w_d_nxt;
    end
  end

  assign p = r_p;
  assign d = r_d;

endmodule

// File: rtl/mux_n_seq.sv
// Registered N-channel, W-bit multiplexer with enable and auto-scan mode.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   i    - flattened inputs, channel k at [k*W +: W]
//   s    - channel select (direct mode)
//   mode - 0 direct select, 1 auto-scan
//   en   - sample/advance enable
//   y    - registered selected data
//   ch   - index of the channel driving y
//   vld  - y/ch updated this cycle and legal
module mux_n_seq
  import mux_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned W     = 1,
  parameter  int unsigned DWELL = 1,
  localparam int unsigned SW    = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] i,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  ch,
  output logic           vld
);

  localparam int unsigned DW    = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [SW:0] N_LIM = (SW + 1)'(N);

  logic [W-1:0]  r_y;
  logic [SW-1:0] r_ch;
  logic          r_vld;
  logic          r_pm;

  logic [SW-1:0] w_p;
  logic [DW-1:0] w_d;
  logic          w_entry;
  logic          w_clr;
  logic [SW-1:0] w_p_sel;
  logic          w_s_bad;
  logic [W-1:0]  w_y_nxt;
  logic [SW-1:0] w_ch_nxt;
  logic          w_vld_nxt;

  // First enabled scan cycle after direct mode always starts at channel 0
  assign w_entry = (mode == MODE_SCAN) && (r_pm == MODE_DIRECT);
  assign w_clr   = w_entry || (mode == MODE_DIRECT);
  assign w_p_sel = w_entry ? '0 : w_p;
  // Only reachable when N is not a power of two
  assign w_s_bad = ({1'b0, s} >= N_LIM);

  scan_ctr #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan_ctr (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (w_clr),
    .adv (mode),
    .p   (w_p),
    .d   (w_d)
  );

  // Output select: scan pointer, direct select, or out-of-range direct select
  always_comb begin
    w_y_nxt   = r_y;
    w_ch_nxt  = r_ch;
    w_vld_nxt = 1'b0;
    if (en) begin
      if (mode == MODE_SCAN) begin
        w_y_nxt   = W'(chan_slice(MAX_BUS_W'(i), 32'(w_p_sel), W));
        w_ch_nxt  = w_p_sel;
        w_vld_nxt = 1'b1;
      end else if (w_s_bad) begin
        w_y_nxt   = '0;
        w_ch_nxt  = s;
        w_vld_nxt = 1'b0;
      end else begin
        w_y_nxt   = W'(chan_slice(MAX_BUS_W'(i), 32'(s), W));
        w_ch_nxt  = s;
        w_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y   <= '0;
      r_ch  <= '0;
      r_vld <= 1'b0;
      r_pm  <= MODE_DIRECT;
    end else begin
      r_y   <= w_y_nxt;
      r_ch  <= w_ch_nxt;
      r_vld <= w_vld_nxt;
      if (en) begin
        r_pm <= mode;
      end
    end
  end

  // Dwell counter never leaves 0..DWELL-1
  a_dwell_range : assert property (@(posedge clk) disable iff (rst) w_d <= DW'(DWELL - 1));

  assign y   = r_y;
  assign ch  = r_ch;
  assign vld = r_vld;

endmodule

// File: tb/tb_mux_n_seq.sv
// Self-checking bench for mux_n_seq: a 4-channel DWELL=2 instance and a 3-channel DWELL=1 instance.
module tb_mux_n_seq;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] s;
    logic [7:0] y;
    logic [1:0] ch;
    logic       vld;
  } vec_t;

  typedef struct {
    bit   sel;
    vec_t v;
    int   idx;
  } sb_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_mode, a_en;
  logic [31:0] a_i;
  logic [1:0]  a_s;
  logic [7:0]  a_y;
  logic [1:0]  a_ch;
  logic        a_vld;

  logic        b_rst, b_mode, b_en;
  logic [23:0] b_i;
  logic [1:0]  b_s;
  logic [7:0]  b_y;
  logic [1:0]  b_ch;
  logic        b_vld;

  mux_n_seq #(.N(4), .W(8), .DWELL(2)) u_a (
    .clk (clk), .rst (a_rst), .i (a_i), .s (a_s), .mode (a_mode), .en (a_en),
    .y (a_y), .ch (a_ch), .vld (a_vld)
  );

  mux_n_seq #(.N(3), .W(8), .DWELL(1)) u_b (
    .clk (clk), .rst (b_rst), .i (b_i), .s (b_s), .mode (b_mode), .en (b_en),
    .y (b_y), .ch (b_ch), .vld (b_vld)
  );

  int  n_cmp = 0;
  int  n_err = 0;
  int  step_no = 0;
  sb_t sb[$];

  function automatic vec_t mk(logic rst, logic en, logic mode, logic [1:0] s,
                              logic [7:0] y, logic [1:0] ch, logic vld);
    vec_t t;
    t.rst = rst; t.en = en; t.mode = mode; t.s = s;
    t.y = y; t.ch = ch; t.vld = vld;
    return t;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then score after the edge
  task automatic apply(input bit sel, input vec_t t);
    sb_t        e;
    logic [7:0] gy;
    logic [1:0] gch;
    logic       gv;
    @(negedge clk);
    if (!sel) begin
      a_rst = t.rst; a_en = t.en; a_mode = t.mode; a_s = t.s;
    end else begin
      b_rst = t.rst; b_en = t.en; b_mode = t.mode; b_s = t.s;
    end
    step_no++;
    sb.push_back('{sel: sel, v: t, idx: step_no});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    gy  = e.sel ? b_y   : a_y;
    gch = e.sel ? b_ch  : a_ch;
    gv  = e.sel ? b_vld : a_vld;
    n_cmp++;
    if ({gy, gch, gv} !== {e.v.y, e.v.ch, e.v.vld}) begin
      n_err++;
      $display("FAIL dut%s step %0d: got y=%h ch=%0d vld=%0d, want y=%h ch=%0d vld=%0d",
               e.sel ? "B" : "A", e.idx, gy, gch, gv, e.v.y, e.v.ch, e.v.vld);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t ta[$];
    logic [1:0] c;

    a_rst = 1'b1; a_en = 1'b0; a_mode = 1'b0; a_s = '0; a_i = 32'h4433_2211;
    b_rst = 1'b1; b_en = 1'b0; b_mode = 1'b0; b_s = '0; b_i = 24'hCC_BB_AA;
    repeat (2) @(posedge clk);

    // Reset state, direct select over all channels, then scan with wrap while s toggles
    ta.push_back(mk(1, 0, 0, 2'd0, 8'h00, 2'd0, 0));
    ta.push_back(mk(1, 1, 1, 2'd2, 8'h00, 2'd0, 0));
    ta.push_back(mk(0, 1, 0, 2'd0, 8'h11, 2'd0, 1));
    ta.push_back(mk(0, 1, 0, 2'd1, 8'h22, 2'd1, 1));
    ta.push_back(mk(0, 1, 0, 2'd2, 8'h33, 2'd2, 1));
    ta.push_back(mk(0, 1, 0, 2'd3, 8'h44, 2'd3, 1));
    for (int k = 0; k < 10; k++) begin
      c = 2'((k / 2) % 4);
      ta.push_back(mk(0, 1, 1, 2'(k), 8'(8'h11 * (c + 1)), c, 1));
    end
    foreach (ta[k]) apply(1'b0, ta[k]);

    // Continue scan to p=2/d=1, then gate enable for 3 cycles
    apply(1'b0, mk(0, 1, 1, 2'd3, 8'h22, 2'd1, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h22, 2'd1, 1));
    apply(1'b0, mk(0, 1, 1, 2'd1, 8'h33, 2'd2, 1));
    apply(1'b0, mk(0, 1, 1, 2'd2, 8'h33, 2'd2, 1));
    for (int k = 0; k < 3; k++) apply(1'b0, mk(0, 0, 1, 2'(k), 8'h33, 2'd2, 0));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h44, 2'd3, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h44, 2'd3, 1));

    // Scan up to p=3, exit to direct s=1, re-enter scan at channel 0
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h11, 2'd0, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h11, 2'd0, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h22, 2'd1, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h22, 2'd1, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h33, 2'd2, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h33, 2'd2, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h44, 2'd3, 1));
    apply(1'b0, mk(0, 1, 0, 2'd1, 8'h22, 2'd1, 1));
    apply(1'b0, mk(0, 1, 1, 2'd3, 8'h11, 2'd0, 1));
    apply(1'b0, mk(0, 1, 1, 2'd3, 8'h11, 2'd0, 1));
    apply(1'b0, mk(0, 1, 1, 2'd3, 8'h22, 2'd1, 1));

    // Mode change while disabled is deferred; scan continues where it was frozen
    apply(1'b0, mk(0, 0, 0, 2'd2, 8'h22, 2'd1, 0));
    apply(1'b0, mk(0, 1, 1, 2'd2, 8'h22, 2'd1, 1));
    apply(1'b0, mk(0, 1, 1, 2'd2, 8'h33, 2'd2, 1));

    // Reset mid-scan with en high, then scan restarts at channel 0
    apply(1'b0, mk(1, 1, 1, 2'd0, 8'h00, 2'd0, 0));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h11, 2'd0, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h11, 2'd0, 1));
    apply(1'b0, mk(0, 1, 1, 2'd0, 8'h22, 2'd1, 1));

    // Non-power-of-two N=3: out-of-range select, legal selects, DWELL=1 scan wrap
    apply(1'b1, mk(1, 0, 0, 2'd0, 8'h00, 2'd0, 0));
    apply(1'b1, mk(0, 1, 0, 2'd3, 8'h00, 2'd3, 0));
    apply(1'b1, mk(0, 1, 0, 2'd2, 8'hCC, 2'd2, 1));
    apply(1'b1, mk(0, 1, 0, 2'd0, 8'hAA, 2'd0, 1));
    apply(1'b1, mk(0, 1, 1, 2'd3, 8'hAA, 2'd0, 1));
    apply(1'b1, mk(0, 1, 1, 2'd3, 8'hBB, 2'd1, 1));
    apply(1'b1, mk(0, 1, 1, 2'd3, 8'hCC, 2'd2, 1));
    apply(1'b1, mk(0, 1, 1, 2'd3, 8'hAA, 2'd0, 1));
    apply(1'b1, mk(0, 1, 0, 2'd3, 8'h00, 2'd3, 0));

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
